// File: rtl/piso_shift_reg_tx_if.sv
// Handshake/serial bundle for the parallel-in/serial-out transmit register.
// master: word producer and serial consumer; slave: piso_shift_reg_tx itself.
interface piso_shift_reg_tx_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_last;
   logic             busy;

   modport master (
      output data_in, load_valid,
      input  load_ready, ser_out, ser_valid, ser_last, busy
   );

   modport slave (
      input  data_in, load_valid,
      output load_ready, ser_out, ser_valid, ser_last, busy
   );
endinterface

// File: rtl/piso_shift_reg_tx.sv
// Parallel-in/serial-out transmit register.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per clock, MSB or LSB first, with ser_valid/ser_last framing.
// Optional feature: define PIPO_TX_PARITY_EN to append an even-parity bit
// to every frame (ser_last then marks the parity bit).
module piso_shift_reg_tx #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   piso_shift_reg_tx_if.slave   bus
);

   localparam int unsigned    CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  PREV_IDX = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT
`ifdef PIPO_TX_PARITY_EN
      , PARITY
`endif
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  shreg;
   logic [CW-1:0]     bitcnt;
`ifdef PIPO_TX_PARITY_EN
   logic              par_q;
`endif

   logic              accept_c;
   logic [WIDTH-1:0]  shifted_c;
   logic              first_c;
   logic              next_c;

   // Shift direction and the bit that goes out first / next.
   always_comb begin
      shifted_c = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      first_c   = MSB_FIRST ? bus.data_in[WIDTH-1] : bus.data_in[0];
      next_c    = MSB_FIRST ? shifted_c[WIDTH-1]   : shifted_c[0];
   end

   // Ready when idle or while the final bit of the current frame is on the wire.
`ifdef PIPO_TX_PARITY_EN
   assign bus.load_ready = (state == IDLE) | ((state == PARITY) & bus.ser_last);
`else
   assign bus.load_ready = (state == IDLE) | bus.ser_last;
`endif

   assign accept_c = bus.load_valid & bus.load_ready;

   // Frame FSM: capture on accept, shift each cycle, outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         shreg         <= '0;
         bitcnt        <= '0;
         bus.ser_out   <= 1'b0;
         bus.ser_valid <= 1'b0;
         bus.ser_last  <= 1'b0;
         bus.busy      <= 1'b0;
`ifdef PIPO_TX_PARITY_EN
         par_q         <= 1'b0;
`endif
      end else if (accept_c) begin
         // New word: first bit goes straight onto the wire next cycle.
         state         <= SHIFT;
         shreg         <= bus.data_in;
         bitcnt        <= '0;
         bus.ser_out   <= first_c;
         bus.ser_valid <= 1'b1;
         bus.ser_last  <= 1'b0;
         bus.busy      <= 1'b1;
`ifdef PIPO_TX_PARITY_EN
         par_q         <= ^bus.data_in;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (bitcnt == LAST_IDX) begin
`ifdef PIPO_TX_PARITY_EN
                  state         <= PARITY;
                  bitcnt        <= CW'(WIDTH);
                  bus.ser_out   <= par_q;
                  bus.ser_last  <= 1'b1;
`else
                  state         <= IDLE;
                  bitcnt        <= '0;
                  bus.ser_out   <= 1'b0;
                  bus.ser_valid <= 1'b0;
                  bus.ser_last  <= 1'b0;
                  bus.busy      <= 1'b0;
`endif
               end else begin
                  shreg         <= shifted_c;
                  bitcnt        <= bitcnt + 1'b1;
                  bus.ser_out   <= next_c;
`ifndef PIPO_TX_PARITY_EN
                  bus.ser_last  <= (bitcnt == PREV_IDX);
`endif
               end
            end
`ifdef PIPO_TX_PARITY_EN
            PARITY: begin
               state         <= IDLE;
               bitcnt        <= '0;
               bus.ser_out   <= 1'b0;
               bus.ser_valid <= 1'b0;
               bus.ser_last  <= 1'b0;
               bus.busy      <= 1'b0;
            end
`endif
            default: begin
               state         <= IDLE;
               bitcnt        <= '0;
               bus.ser_out   <= 1'b0;
               bus.ser_valid <= 1'b0;
               bus.ser_last  <= 1'b0;
               bus.busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_shift_reg_tx.sv
// Bench for piso_shift_reg_tx: one MSB-first and one LSB-first instance fed
// the same stimulus; a per-instance bit queue predicts every serial cycle.
module tb_piso_shift_reg_tx;

   localparam int unsigned W = 4;
`ifdef PIPO_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int unsigned FL = W + 32'(PAR);

   // Directed frame expectations, first bit on the wire in the MSB of each constant.
   localparam logic [31:0] E_B_MSB  = PAR ? 32'b10111      : 32'b1011;
   localparam logic [31:0] E_B_LSB  = PAR ? 32'b11011      : 32'b1101;
   localparam logic [31:0] E_A5_MSB = PAR ? 32'b1010001010 : 32'b10100101;
   localparam logic [31:0] E_9_MSB  = PAR ? 32'b10010      : 32'b1001;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] data_in;
   logic         load_valid;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam bit MSB = (gi == 0);

      piso_shift_reg_tx_if #(.WIDTH(W)) bus ();
      assign bus.data_in    = data_in;
      assign bus.load_valid = load_valid;

      piso_shift_reg_tx #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      logic [1:0]  q [$];          // {bit, last} not yet on the wire
      bit          cur_v = 1'b0;
      logic        cur_b = 1'b0;
      logic        cur_l = 1'b0;
      logic [63:0] log   = '0;     // every observed serial bit, shifted in

      // Reference model: decide acceptance and advance one bit per clock.
      always @(posedge clk or negedge rst_n) begin : model
         logic rdy;
         if (!rst_n) begin
            q.delete();
            cur_v = 1'b0;
            cur_b = 1'b0;
            cur_l = 1'b0;
         end else begin
            rdy = !cur_v || cur_l;
            if (load_valid && rdy) begin
               for (int k = 0; k < W; k++)
                  q.push_back({(MSB ? data_in[W-1-k] : data_in[k]), ((k == W-1) && !PAR)});
               if (PAR) q.push_back({^data_in, 1'b1});
            end
            if (q.size() > 0) begin
               {cur_b, cur_l} = q.pop_front();
               cur_v = 1'b1;
            end else begin
               cur_v = 1'b0;
               cur_b = 1'b0;
               cur_l = 1'b0;
            end
         end
      end

      // Compare every output against the model away from the active edge.
      always @(negedge clk) begin
         if (rst_n) begin
            check($sformatf("ser_valid[%0d]", gi),  32'(bus.ser_valid),  32'(cur_v));
            check($sformatf("busy[%0d]", gi),       32'(bus.busy),       32'(cur_v));
            check($sformatf("ser_out[%0d]", gi),    32'(bus.ser_out),    32'(cur_v & cur_b));
            check($sformatf("ser_last[%0d]", gi),   32'(bus.ser_last),   32'(cur_v & cur_l));
            check($sformatf("load_ready[%0d]", gi), 32'(bus.load_ready), 32'(!cur_v || cur_l));
            if (bus.ser_valid) log = {log[62:0], bus.ser_out};
         end
      end
   end

   task automatic wait_idle();
      int budget = 40;
      do begin
         @(negedge clk);
         budget--;
      end while ((g_dut[0].cur_v || g_dut[1].cur_v) && budget > 0);
      check("idle_timeout", 32'(g_dut[0].cur_v || g_dut[1].cur_v), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      load_valid = 1'b0;
      data_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ser_valid", 32'(g_dut[0].bus.ser_valid), 32'd0);
      check("rst_ser_out",   32'(g_dut[0].bus.ser_out),   32'd0);
      check("rst_busy",      32'(g_dut[0].bus.busy),      32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(g_dut[0].bus.load_ready), 32'd1);
      check("post_rst_valid", 32'(g_dut[1].bus.ser_valid),  32'd0);

      // Single frame 4'b1011 in both bit orders.
      load_valid = 1'b1;
      data_in    = 4'b1011;
      @(negedge clk) load_valid = 1'b0;
      data_in = 4'h0;
      wait_idle();
      check("frame_b_msb", 32'(g_dut[0].log[FL-1:0]), E_B_MSB);
      check("frame_b_lsb", 32'(g_dut[1].log[FL-1:0]), E_B_LSB);

      // Back-to-back 4'hA then 4'h5 with load_valid held.
      load_valid = 1'b1;
      data_in    = 4'hA;
      @(negedge clk) data_in = 4'h5;
      repeat (FL) @(negedge clk);
      load_valid = 1'b0;
      wait_idle();
      check("b2b_a5_msb", 32'(g_dut[0].log[2*FL-1:0]), E_A5_MSB);

      // 4'hC, ignored 4'h3 during bit 2, async reset during bit 3.
      load_valid = 1'b1;
      data_in    = 4'hC;
      @(negedge clk) load_valid = 1'b0;
      @(negedge clk);
      load_valid = 1'b1;
      data_in    = 4'h3;
      @(negedge clk);
      load_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("abort_valid0", 32'(g_dut[0].bus.ser_valid), 32'd0);
      check("abort_out0",   32'(g_dut[0].bus.ser_out),   32'd0);
      check("abort_busy1",  32'(g_dut[1].bus.busy),      32'd0);
      check("abort_last1",  32'(g_dut[1].bus.ser_last),  32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // Frame 4'b1001 (even parity 0 when enabled).
      load_valid = 1'b1;
      data_in    = 4'b1001;
      @(negedge clk) load_valid = 1'b0;
      wait_idle();
      check("frame_9_msb", 32'(g_dut[0].log[FL-1:0]), E_9_MSB);

      // Random valid/data traffic, including stalls and back-to-back loads.
      for (int i = 0; i < 80; i++) begin
         load_valid = 1'($urandom_range(0, 1));
         data_in    = W'($urandom);
         @(negedge clk);
      end
      load_valid = 1'b0;
      wait_idle();
      check("q0_empty", 32'(g_dut[0].q.size()), 32'd0);
      check("q1_empty", 32'(g_dut[1].q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
